// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks the RF debug port FIRST_REG..LAST_REG and
// streams each sampled value as an index/data word on valid/ready.
module rf_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic [5:0]  count
);

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    SEND,
    DONE
  } state_t;

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  state_t state;
  logic   at_last;
  logic   skip;
  logic   hs;

  assign at_last  = (reg_sel == LAST);
  assign skip     = SKIP_ZERO && (reg_data == '0);
  assign hs       = out_valid && out_ready;
  assign out_last = out_valid && (out_idx == LAST);

  // Scan sequencer: select, sample, hold word until accepted, advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      reg_sel   <= FIRST;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else if (abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= SEL;
            reg_sel <= FIRST;
            count   <= '0;
            busy    <= 1'b1;
          end
        end
        SEL: begin
          out_idx  <= reg_sel;
          out_data <= reg_data;
          if (skip) begin
            if (at_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              reg_sel <= reg_sel + 5'd1;
            end
          end else begin
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            count     <= count + 6'd1;
            if (at_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              reg_sel <= reg_sel + 5'd1;
              state   <= SEL;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader: three reader instances (default, skip-zero,
// narrow range) checked against a word-level reference model.
module tb_rf_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [2:0]  start, abort, rdy;
  logic [4:0]  rs [3];
  logic [31:0] rd [3];
  logic [2:0]  ov, olast, busy, done;
  logic [4:0]  oidx [3];
  logic [31:0] odat [3];
  logic [5:0]  cnt [3];
  logic [31:0] rf [3][32];
  logic [31:0] snap [3][32];
  int          rmode [3];

  // RF debug port: combinational read, r0 is hard zero.
  always_comb begin
    for (int k = 0; k < 3; k++)
      rd[k] = (rs[k] == 5'd0) ? 32'd0 : rf[k][rs[k]];
  end

  rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(1'b0)) u0 (
    .clk(clk), .rstn(rstn), .start(start[0]), .abort(abort[0]),
    .reg_sel(rs[0]), .reg_data(rd[0]), .out_valid(ov[0]),
    .out_ready(rdy[0]), .out_idx(oidx[0]), .out_data(odat[0]),
    .out_last(olast[0]), .busy(busy[0]), .done(done[0]),
    .count(cnt[0]));

  rf_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(1'b1)) u1 (
    .clk(clk), .rstn(rstn), .start(start[1]), .abort(abort[1]),
    .reg_sel(rs[1]), .reg_data(rd[1]), .out_valid(ov[1]),
    .out_ready(rdy[1]), .out_idx(oidx[1]), .out_data(odat[1]),
    .out_last(olast[1]), .busy(busy[1]), .done(done[1]),
    .count(cnt[1]));

  rf_dump_reader #(.FIRST_REG(8), .LAST_REG(11), .SKIP_ZERO(1'b0)) u2 (
    .clk(clk), .rstn(rstn), .start(start[2]), .abort(abort[2]),
    .reg_sel(rs[2]), .reg_data(rd[2]), .out_valid(ov[2]),
    .out_ready(rdy[2]), .out_idx(oidx[2]), .out_data(odat[2]),
    .out_last(olast[2]), .busy(busy[2]), .done(done[2]),
    .count(cnt[2]));

  function automatic int fr(input int k);
    return (k == 2) ? 8 : 0;
  endfunction
  function automatic int lr(input int k);
    return (k == 2) ? 11 : 31;
  endfunction
  function automatic bit sz(input int k);
    return (k == 1);
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Reference model state: expected word list, accepted count,
  // and the edge after which done must be visible.
  int          edge_n = 0;
  bit          act [3];
  int          acc [3];
  int          due [3];
  bit          hsf [3];
  int          qv [3][32];
  int          qh [3];
  int          qn [3];
  logic [31:0] held [3];
  bit          pov [3];
  logic [36:0] lg [3][64];
  int          ln [3];

  task automatic model_step();
    int j;
    edge_n++;
    snap = rf;
    for (int k = 0; k < 3; k++) begin
      hsf[k] = 1'b0;
      if (!rstn) begin
        act[k] = 1'b0;
        acc[k] = 0;
        due[k] = -1;
        qh[k]  = 0;
        qn[k]  = 0;
      end else if (act[k]) begin
        if (abort[k]) begin
          act[k] = 1'b0;
          due[k] = -1;
          qn[k]  = 0;
        end else begin
          if (ov[k] && rdy[k] && qn[k] > 0) begin
            hsf[k] = 1'b1;
            acc[k]++;
            j = qv[k][qh[k]];
            if (ln[k] < 64) lg[k][ln[k]] = {oidx[k], odat[k]};
            ln[k]++;
            qh[k]++;
            qn[k]--;
            if (qn[k] == 0) due[k] = edge_n + lr(k) - j;
          end
          if (edge_n == due[k]) act[k] = 1'b0;
        end
      end else if (!(due[k] >= 0 && edge_n == due[k] + 1) &&
                   start[k] && !abort[k]) begin
        act[k] = 1'b1;
        acc[k] = 0;
        qh[k]  = 0;
        qn[k]  = 0;
        for (int i = fr(k); i <= lr(k); i++) begin
          if (!sz(k) || (i != 0 && rf[k][i] != 0)) begin
            qv[k][qn[k]] = i;
            qn[k]++;
          end
        end
        due[k] = (qn[k] == 0) ? edge_n + 1 + lr(k) - fr(k) : -1;
      end
    end
  endtask

  task automatic check_step();
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        chk("rst_valid", ov[k], 0);
        chk("rst_idx", oidx[k], 0);
        chk("rst_data", odat[k], 0);
        chk("rst_busy", busy[k], 0);
        chk("rst_done", done[k], 0);
        chk("rst_count", cnt[k], 0);
        chk("rst_reg_sel", rs[k], fr(k));
        pov[k] = 1'b0;
      end else begin
        chk("done", done[k], (due[k] == edge_n));
        chk("busy", busy[k], act[k]);
        chk("count", cnt[k], acc[k]);
        chk("last", olast[k], ov[k] && (oidx[k] == 5'(lr(k))));
        if (!act[k] || hsf[k]) chk("valid_low", ov[k], 0);
        if (ov[k]) begin
          if (qn[k] == 0) begin
            chk("extra_word", ov[k], 0);
          end else begin
            chk("word_idx", oidx[k], qv[k][qh[k]]);
            if (!pov[k]) held[k] = snap[k][qv[k][qh[k]]];
            chk("word_data", odat[k], held[k]);
          end
        end
        pov[k] = ov[k];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check_step();
  end

  // Ready driver: 0 off, 1 on, 2 one-in-three, 3 coin flip.
  initial begin
    rdy = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        case (rmode[k])
          0: rdy[k] = 1'b0;
          1: rdy[k] = 1'b1;
          2: rdy[k] = ($urandom_range(0, 2) == 0);
          default: rdy[k] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  task automatic go(input int k, output int s);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    s = edge_n;
  endtask

  task automatic wait_done(input int k, input int budget, output int e);
    e = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done[k]) begin
        e = edge_n;
        break;
      end
    end
    if (e < 0) chk("done_timeout", done[k], 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int s, e, n, k;
  bit found;

  initial begin
    rstn  = 1'b0;
    start = '0;
    abort = '0;
    for (int q = 0; q < 3; q++) begin
      rmode[q] = 0;
      ln[q]    = 0;
      for (int i = 0; i < 32; i++) rf[q][i] = '0;
    end
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;

    // Full default scan, ready always high.
    for (int i = 1; i < 32; i++) rf[0][i] = 32'h100 + i;
    rmode[0] = 1;
    ln[0] = 0;
    go(0, s);
    wait_done(0, 200, e);
    chk("A_done_latency", e - s, 64);
    chk("A_count", cnt[0], 32);
    chk("A_words", ln[0], 32);
    chk("A_w0", lg[0][0], {5'd0, 32'h0});
    chk("A_w1", lg[0][1], {5'd1, 32'h101});
    chk("A_w31", lg[0][31], {5'd31, 32'h11F});
    @(negedge clk);
    chk("A_done_pulse", done[0], 0);
    chk("A_reg_sel_hold", rs[0], 31);

    // Throttled ready, random data, start while busy ignored.
    for (int i = 1; i < 32; i++) rf[0][i] = $urandom;
    rmode[0] = 2;
    ln[0] = 0;
    go(0, s);
    repeat (5) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 400, e);
    chk("B_count", cnt[0], 32);
    chk("B_words", ln[0], 32);

    // Skip-zero scan with two nonzero registers.
    rf[1][5]  = 32'hDEADBEEF;
    rf[1][31] = 32'h1;
    rmode[1] = 1;
    ln[1] = 0;
    go(1, s);
    wait_done(1, 200, e);
    chk("C_words", ln[1], 2);
    chk("C_w0", lg[1][0], {5'd5, 32'hDEADBEEF});
    chk("C_w1", lg[1][1], {5'd31, 32'h1});
    chk("C_count", cnt[1], 2);

    // Narrow range; r9 rewritten between select and sample.
    for (int i = 8; i < 12; i++) rf[2][i] = 32'h1000 + i;
    rmode[2] = 1;
    ln[2] = 0;
    go(2, s);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (rs[2] == 5'd9 && busy[2] && !ov[2]) begin
        rf[2][9] = 32'hAAAA5555;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("D_sel9_seen", found, 1);
    wait_done(2, 100, e);
    chk("D_words", ln[2], 4);
    chk("D_w0", lg[2][0], {5'd8, 32'h1008});
    chk("D_w1", lg[2][1], {5'd9, 32'hAAAA5555});

    // Abort while idx 6 is waiting, then rescan.
    for (int i = 1; i < 32; i++) rf[0][i] = 32'h100 + i;
    rmode[0] = 1;
    ln[0] = 0;
    go(0, s);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (ov[0] && oidx[0] == 5'd6) found = 1'b1;
      else @(negedge clk);
    end
    chk("E_idx6_seen", found, 1);
    rmode[0] = 0;
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("E_valid", ov[0], 0);
    chk("E_busy", busy[0], 0);
    chk("E_done", done[0], 0);
    chk("E_count", cnt[0], 6);
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("E_abort_wins", busy[0], 0);
    rmode[0] = 1;
    ln[0] = 0;
    go(0, s);
    wait_done(0, 200, e);
    chk("E_rescan_words", ln[0], 32);
    chk("E_rescan_w0", lg[0][0], {5'd0, 32'h0});

    // Randomized scans with random writes and random aborts.
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(0, 2);
      for (int i = 1; i < 32; i++) begin
        if (k == 1) rf[k][i] = $urandom_range(0, 1) ? $urandom : 32'h0;
        else rf[k][i] = $urandom;
      end
      rmode[k] = $urandom_range(1, 3);
      go(k, s);
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, 40);
        repeat (n) @(negedge clk);
        abort[k] = 1'b1;
        @(negedge clk);
        abort[k] = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        e = -1;
        for (int c = 0; c < 400 && e < 0; c++) begin
          @(negedge clk);
          if (done[k]) e = edge_n;
          else if (k != 1 && $urandom_range(0, 7) == 0)
            rf[k][$urandom_range(1, 31)] = $urandom;
        end
        if (e < 0) chk("R_done_timeout", done[k], 1);
      end
    end

    // Reset in the middle of a held word.
    rmode[0] = 0;
    go(0, s);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (ov[0]) found = 1'b1;
      else @(negedge clk);
    end
    chk("F_send_seen", found, 1);
    #2 rstn = 1'b0;
    #1;
    chk("F_async_valid", ov[0], 0);
    chk("F_async_busy", busy[0], 0);
    chk("F_async_count", cnt[0], 0);
    chk("F_async_data", odat[0], 0);
    chk("F_async_sel", rs[0], 0);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    rmode[0] = 1;
    ln[0] = 0;
    go(0, s);
    wait_done(0, 200, e);
    chk("F_recover_words", ln[0], 32);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
